// File: rtl/tx_uart.sv
// UART transmitter: serialises one word per request as start, data (LSB first),
// optional parity and stop bits, each bit lasting 16 oversampling ticks.
module tx_uart #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    localparam int BIT_W = $clog2(DATA_BITS) + 1;
    localparam logic [4:0] BIT_END = 5'd15;
    localparam logic [4:0] STOP_END = 5'(STOP_BITS * 16 - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_PARITY = 5'b01000,
        S_STOP   = 5'b10000
    } state_t;

    state_t               state;
    logic [4:0]           tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;

    // o_tx is always loaded with the value of the bit being entered, so the
    // line changes on the same edge as the state and never sees the inputs directly.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= S_IDLE;
            o_tx       <= 1'b1;
            o_busy     <= 1'b0;
            o_tx_done  <= 1'b0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_tx <= 1'b1;
                    if (i_tx_start) begin
                        shift_reg  <= i_data;
                        parity_bit <= (PARITY == 1) ? ~^i_data : ^i_data;
                        tick_cnt   <= '0;
                        bit_cnt    <= '0;
                        state      <= S_START;
                        o_tx       <= 1'b0;
                        o_busy     <= 1'b1;
                    end
                end
                S_START: begin
                    if (i_tick) begin
                        if (tick_cnt == BIT_END) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= S_DATA;
                            o_tx     <= shift_reg[0];
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (i_tick) begin
                        if (tick_cnt == BIT_END) begin
                            tick_cnt  <= '0;
                            shift_reg <= shift_reg >> 1;
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                if (PARITY != 0) begin
                                    state <= S_PARITY;
                                    o_tx  <= parity_bit;
                                end else begin
                                    state <= S_STOP;
                                    o_tx  <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                o_tx    <= shift_reg[1];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (i_tick) begin
                        if (tick_cnt == BIT_END) begin
                            tick_cnt <= '0;
                            state    <= S_STOP;
                            o_tx     <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                S_STOP: begin
                    // The stop span covers all stop bits in one count, hence the 5-bit counter.
                    if (i_tick) begin
                        if (tick_cnt == STOP_END) begin
                            tick_cnt  <= '0;
                            state     <= S_IDLE;
                            o_tx_done <= 1'b1;
                            o_busy    <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_uart.sv
// Bench for tx_uart: several parameterisations driven from a shared tick, each frame
// compared cycle by cycle against a tick-count model of the expected line.
module tb_tx_uart;

    localparam int NDUT = 5;
    localparam int DB  [NDUT] = '{8, 8, 8, 8, 6};
    localparam int PAR [NDUT] = '{0, 1, 2, 0, 1};
    localparam int STP [NDUT] = '{1, 1, 1, 2, 2};

    logic       clock;
    logic       reset;
    logic       tick;
    logic       start [NDUT];
    logic [7:0] data  [NDUT];
    logic       tx    [NDUT];
    logic       busy  [NDUT];
    logic       done  [NDUT];

    int checks = 0;
    int errors = 0;
    int tick_period = 4;
    int phase = 0;

    bit   exp_bits [$];
    logic rx_bits  [$];
    int   frame_cycles;
    int   done_count;

    tx_uart #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) dut0 (
        .i_clock(clock), .i_reset(reset), .i_tick(tick), .i_tx_start(start[0]),
        .i_data(data[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_tx_done(done[0]));
    tx_uart #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(1)) dut1 (
        .i_clock(clock), .i_reset(reset), .i_tick(tick), .i_tx_start(start[1]),
        .i_data(data[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_tx_done(done[1]));
    tx_uart #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) dut2 (
        .i_clock(clock), .i_reset(reset), .i_tick(tick), .i_tx_start(start[2]),
        .i_data(data[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_tx_done(done[2]));
    tx_uart #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(0)) dut3 (
        .i_clock(clock), .i_reset(reset), .i_tick(tick), .i_tx_start(start[3]),
        .i_data(data[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_tx_done(done[3]));
    tx_uart #(.DATA_BITS(6), .STOP_BITS(2), .PARITY(1)) dut4 (
        .i_clock(clock), .i_reset(reset), .i_tick(tick), .i_tx_start(start[4]),
        .i_data(data[4][5:0]), .o_tx(tx[4]), .o_busy(busy[4]), .o_tx_done(done[4]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Tick changes 2 time units after the edge, so it is readable both at the negedge
    // (value for the coming edge) and at posedge+1 (value the DUT just used).
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            phase++;
            if (phase >= tick_period) phase = 0;
            tick = (phase == 0);
        end
    end

    task automatic model_frame(input int w, input logic [7:0] d);
        logic [7:0] m;
        int ones;
        exp_bits.delete();
        m = d & 8'((1 << DB[w]) - 1);
        ones = $countones(m);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < DB[w]; i++) exp_bits.push_back(m[i]);
        if (PAR[w] == 1) exp_bits.push_back(ones % 2 == 0);
        else if (PAR[w] == 2) exp_bits.push_back(ones % 2 == 1);
        for (int i = 0; i < STP[w]; i++) exp_bits.push_back(1'b1);
    endtask

    function automatic logic [7:0] decoded(input int db);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < db; i++)
            if (1 + i < rx_bits.size()) r[i] = rx_bits[1 + i];
        return r;
    endfunction

    // Runs one frame on DUT w; expected line after k counted ticks is bit k/16 of the frame.
    task automatic run_frame(input string name, input int w, input logic [7:0] d,
                             input bit pre, input bit chain, input logic [7:0] next_d,
                             input int poke_k, input int reset_k);
        int k, total, n, guard, ferr;
        bit finished, poked;
        logic exp_tx, exp_busy, exp_done;
        model_frame(w, d);
        total = exp_bits.size() * 16;
        rx_bits.delete();
        frame_cycles = 0;
        done_count = 0;
        if (!pre) begin
            guard = 0;
            do begin @(negedge clock); guard++; end while (tick !== 1'b1 && guard < 50);
            start[w] = 1'b1;
            data[w] = d;
        end
        k = 0; n = 0; ferr = 0; finished = 0; poked = 0;
        while (!finished) begin
            @(posedge clock); #1;
            start[w] = 1'b0;
            if (n > 0 && tick === 1'b1 && k < total) k++;
            exp_tx   = (k < total) ? exp_bits[k / 16] : 1'b1;
            exp_busy = (k < total);
            exp_done = (k == total);
            checks++;
            if ({tx[w], busy[w], done[w]} !== {exp_tx, exp_busy, exp_done}) begin
                errors++; ferr++;
                $display("[TB] FAIL %s cycle %0d tick %0d: tx/busy/done=%b%b%b, required %b%b%b",
                         name, n, k, tx[w], busy[w], done[w], exp_tx, exp_busy, exp_done);
            end
            if (done[w] === 1'b1) done_count++;
            if (rx_bits.size() < exp_bits.size() && k == rx_bits.size() * 16 + 8)
                rx_bits.push_back(tx[w]);
            if (k == total) begin
                finished = 1;
                frame_cycles = n;
            end else if (ferr >= 5 || n >= 20000) begin
                if (n >= 20000) begin
                    checks++; errors++;
                    $display("[TB] FAIL %s timeout: %0d ticks seen, required %0d", name, k, total);
                end
                reset = 1'b1; @(posedge clock); #1; reset = 1'b0;
                return;
            end else if (reset_k >= 0 && k == reset_k) begin
                reset = 1'b1;
                @(posedge clock); #1;
                reset = 1'b0;
                checks++;
                if ({tx[w], busy[w], done[w]} !== 3'b100) begin
                    errors++;
                    $display("[TB] FAIL %s abort: tx/busy/done=%b%b%b, required 100",
                             name, tx[w], busy[w], done[w]);
                end
                for (int i = 0; i < 100; i++) begin
                    @(posedge clock); #1;
                    checks++;
                    if ({tx[w], busy[w], done[w]} !== 3'b100) begin
                        errors++;
                        $display("[TB] FAIL %s post-abort cycle %0d: tx/busy/done=%b%b%b, required 100",
                                 name, i, tx[w], busy[w], done[w]);
                    end
                end
                return;
            end else begin
                data[w] = 8'($urandom);
                if (poke_k >= 0 && !poked && k == poke_k) begin
                    start[w] = 1'b1;
                    data[w] = 8'h12;
                    poked = 1;
                end
            end
            n++;
        end
        if (chain) begin
            start[w] = 1'b1;
            data[w] = next_d;
        end else begin
            for (int i = 0; i < 24; i++) begin
                @(posedge clock); #1;
                checks++;
                if ({tx[w], busy[w], done[w]} !== 3'b100) begin
                    errors++;
                    $display("[TB] FAIL %s idle cycle %0d: tx/busy/done=%b%b%b, required 100",
                             name, i, tx[w], busy[w], done[w]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int w = 0; w < NDUT; w++) begin start[w] = 1'b1; data[w] = 8'($urandom); end
        repeat (3) @(posedge clock);
        #1;
        for (int w = 0; w < NDUT; w++) begin
            checks++;
            if ({tx[w], busy[w], done[w]} !== 3'b100) begin
                errors++;
                $display("[TB] FAIL reset dut%0d: tx/busy/done=%b%b%b, required 100",
                         w, tx[w], busy[w], done[w]);
            end
            start[w] = 1'b0;
        end
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int w = 0; w < NDUT; w++) begin
            checks++;
            if ({tx[w], busy[w], done[w]} !== 3'b100) begin
                errors++;
                $display("[TB] FAIL after_reset dut%0d: tx/busy/done=%b%b%b, required 100",
                         w, tx[w], busy[w], done[w]);
            end
        end
    endtask

    task automatic test_basic_frame();
        tick_period = 4;
        run_frame("t1_55", 0, 8'h55, 0, 0, 8'h00, -1, -1);
        checks++;
        if (frame_cycles !== 640) begin
            errors++;
            $display("[TB] FAIL t1_length: %0d clocks, required 640", frame_cycles);
        end
        checks++;
        if (rx_bits.size() !== 10) begin
            errors++;
            $display("[TB] FAIL t1_bitcount: %0d bits, required 10", rx_bits.size());
        end
        for (int i = 0; i < 10 && i < rx_bits.size(); i++) begin
            checks++;
            if (rx_bits[i] !== 1'(i % 2)) begin
                errors++;
                $display("[TB] FAIL t1_bit%0d: line %b, required %b", i, rx_bits[i], 1'(i % 2));
            end
        end
        checks++;
        if (done_count !== 1) begin
            errors++;
            $display("[TB] FAIL t1_done_pulses: %0d, required 1", done_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] first_byte;
        tick_period = 4;
        run_frame("t2_a3", 0, 8'hA3, 0, 1, 8'h0F, -1, -1);
        first_byte = decoded(8);
        run_frame("t2_0f", 0, 8'h0F, 1, 0, 8'h00, -1, -1);
        checks++;
        if (first_byte !== 8'hA3) begin
            errors++;
            $display("[TB] FAIL t2_byte1: got %h, required a3", first_byte);
        end
        checks++;
        if (decoded(8) !== 8'h0F) begin
            errors++;
            $display("[TB] FAIL t2_byte2: got %h, required 0f", decoded(8));
        end
    endtask

    task automatic test_parity();
        tick_period = 3;
        run_frame("t3_odd", 1, 8'h07, 0, 0, 8'h00, -1, -1);
        checks++;
        if (rx_bits.size() !== 11 || rx_bits[9] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t3_odd: %0d bits parity %b, required 11 bits parity 0",
                     rx_bits.size(), rx_bits.size() > 9 ? rx_bits[9] : 1'bx);
        end
        run_frame("t3_even", 2, 8'h07, 0, 0, 8'h00, -1, -1);
        checks++;
        if (rx_bits.size() !== 11 || rx_bits[9] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL t3_even: %0d bits parity %b, required 11 bits parity 1",
                     rx_bits.size(), rx_bits.size() > 9 ? rx_bits[9] : 1'bx);
        end
    endtask

    task automatic test_stop_bits();
        tick_period = 4;
        run_frame("t4_ff", 3, 8'hFF, 0, 0, 8'h00, -1, -1);
        checks++;
        if (frame_cycles !== 704) begin
            errors++;
            $display("[TB] FAIL t4_length: %0d clocks, required 704", frame_cycles);
        end
        checks++;
        if (rx_bits.size() !== 11) begin
            errors++;
            $display("[TB] FAIL t4_bitcount: %0d bits, required 11", rx_bits.size());
        end
    endtask

    task automatic test_ignore_busy();
        tick_period = 2;
        run_frame("t5_80", 0, 8'h80, 0, 0, 8'h00, 70, -1);
        checks++;
        if (decoded(8) !== 8'h80 || done_count !== 1) begin
            errors++;
            $display("[TB] FAIL t5_ignored: byte %h pulses %0d, required 80 and 1",
                     decoded(8), done_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        tick_period = 2;
        run_frame("t6_abort", 0, 8'($urandom), 0, 0, 8'h00, -1, 85);
        d = 8'($urandom);
        run_frame("t6_after", 0, d, 0, 0, 8'h00, -1, -1);
        checks++;
        if (decoded(8) !== d) begin
            errors++;
            $display("[TB] FAIL t6_after: got %h, required %h", decoded(8), d);
        end
    endtask

    task automatic test_random();
        int w;
        logic [7:0] d, m;
        for (int it = 0; it < 12; it++) begin
            w = $urandom_range(0, NDUT - 1);
            d = 8'($urandom);
            tick_period = $urandom_range(1, 4);
            m = d & 8'((1 << DB[w]) - 1);
            run_frame("rand", w, d, 0, 0, 8'h00, -1, -1);
            checks++;
            if (decoded(DB[w]) !== m) begin
                errors++;
                $display("[TB] FAIL rand_%0d dut%0d: got %h, required %h", it, w, decoded(DB[w]), m);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int w = 0; w < NDUT; w++) begin start[w] = 1'b0; data[w] = 8'h00; end
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_parity();
        test_stop_bits();
        test_ignore_busy();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
